// File: rtl/xsr_pkg.sv
// xsr_pkg: shared types, constants and helper functions for the xoshiro256** arbiter.
//   xsr_state_t     four 64-bit generator state words
//   fsm_t           arbiter sequencer states (SEED, RUN)
//   rotl64          constant-amount 64-bit rotate left
//   splitmix_value  splitmix64 output mix of an already-advanced mix register
package xsr_pkg;

    typedef struct packed {
        logic [63:0] s3;
        logic [63:0] s2;
        logic [63:0] s1;
        logic [63:0] s0;
    } xsr_state_t;

    typedef enum logic {SEED, RUN} fsm_t;

    localparam logic [63:0] SM_GAMMA = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] SM_M1    = 64'hBF58476D1CE4E5B9;
    localparam logic [63:0] SM_M2    = 64'h94D049BB133111EB;

    localparam int unsigned ROT_OUT = 7;   // output scrambler rotation
    localparam int unsigned SHL_T   = 17;  // state-step shift
    localparam int unsigned ROT_S3  = 45;  // state-step rotation of s3

    localparam logic [63:0] MUL_A = 64'd5;
    localparam logic [63:0] MUL_B = 64'd9;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned k);
        return (x << k) | (x >> (64 - k));
    endfunction

    function automatic logic [63:0] splitmix_value(input logic [63:0] mix);
        logic [63:0] z;
        z = mix;
        z = (z ^ (z >> 30)) * SM_M1;
        z = (z ^ (z >> 27)) * SM_M2;
        return z ^ (z >> 31);
    endfunction

endpackage

// File: rtl/xsr_step.sv
// xsr_step: combinational single xoshiro256** step.
//   cur     in   current state words
//   nxt     out  state after one step
//   result  out  rotl(s1*5,7)*9 computed from the pre-step s1
module xsr_step
    import xsr_pkg::*;
(
    input  xsr_state_t  cur,
    output xsr_state_t  nxt,
    output logic [63:0] result
);

    logic [63:0] t;
    logic [63:0] s0, s1, s2, s3;

    assign result = rotl64(cur.s1 * MUL_A, ROT_OUT) * MUL_B;

    always_comb begin
        t  = cur.s1 << SHL_T;
        s0 = cur.s0;
        s1 = cur.s1;
        s2 = cur.s2;
        s3 = cur.s3;
        s2 = s2 ^ s0;
        s3 = s3 ^ s1;
        s1 = s1 ^ s2;
        s0 = s0 ^ s3;
        s2 = s2 ^ t;
        s3 = rotl64(s3, ROT_S3);
        nxt.s0 = s0;
        nxt.s1 = s1;
        nxt.s2 = s2;
        nxt.s3 = s3;
    end

endmodule

// File: rtl/xsr_arbiter.sv
// xsr_arbiter: one xoshiro256** generator shared by NREQ requesters, round-robin.
// After reset the state is expanded from `seed` by four splitmix64 steps (one per cycle),
// then the block serves at most one request per cycle, returning one value per grant.
// Optional build macro XSR_ARB_RESEED_EN adds a `reseed` input that restarts seeding.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   seed       in   64-bit seed, sampled on the first SEED cycle
//   req        in   level requests, held until granted
//   reseed     in   (XSR_ARB_RESEED_EN only) restart seeding from the current seed
//   gnt        out  one-hot combinational grant, zero outside RUN
//   out_valid  out  registered pulse one cycle after a grant
//   out_id     out  requester served by out_data
//   out_data   out  generator output
//   ready      out  high only in RUN
module xsr_arbiter
    import xsr_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [63:0]     seed,
    input  logic [NREQ-1:0] req,
`ifdef XSR_ARB_RESEED_EN
    input  logic            reseed,
`endif
    output logic [NREQ-1:0] gnt,
    output logic            out_valid,
    output logic [IDW-1:0]  out_id,
    output logic [63:0]     out_data,
    output logic            ready
);

    fsm_t        state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [63:0] mix_q, mix_d;
    xsr_state_t  s_q, s_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           out_valid_q, out_valid_d;
    logic [IDW-1:0] out_id_q, out_id_d;
    logic [63:0]    out_data_q, out_data_d;

    logic           reseed_hit;
    logic           win_found;
    logic [IDW-1:0] win_id;
    int unsigned    cand;
    logic           grant_ok;
    logic [63:0]    mix_cur, mix_nxt, sm_val;
    xsr_state_t     step_nxt;
    logic [63:0]    step_result;

`ifdef XSR_ARB_RESEED_EN
    assign reseed_hit = reseed;
`else
    assign reseed_hit = 1'b0;
`endif

    xsr_step u_step (
        .cur    (s_q),
        .nxt    (step_nxt),
        .result (step_result)
    );

    // Round-robin search: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = IDW'(cand);
            end
        end
    end

    assign grant_ok = (state_q == RUN) && win_found && !reseed_hit;
    assign gnt      = grant_ok ? ({{(NREQ-1){1'b0}}, 1'b1} << win_id) : '0;
    assign ready    = (state_q == RUN);

    // The seed is taken directly on idx 0 so a reseed always uses the live seed input.
    assign mix_cur = (idx_q == 2'd0) ? seed : mix_q;
    assign mix_nxt = mix_cur + SM_GAMMA;
    assign sm_val  = splitmix_value(mix_nxt);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mix_d       = mix_q;
        s_d         = s_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            SEED: begin
                if (reseed_hit) begin
                    idx_d = 2'd0;
                end else begin
                    mix_d = mix_nxt;
                    unique case (idx_q)
                        2'd0: s_d.s0 = sm_val;
                        2'd1: s_d.s1 = sm_val;
                        2'd2: s_d.s2 = sm_val;
                        2'd3: s_d.s3 = sm_val;
                        default: ;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (reseed_hit) begin
                    state_d = SEED;
                    idx_d   = 2'd0;
                end else if (grant_ok) begin
                    s_d         = step_nxt;
                    out_data_d  = step_result;
                    out_valid_d = 1'b1;
                    out_id_d    = win_id;
                    rr_ptr_d    = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
                end
            end
            default: begin
                state_d = SEED;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            idx_q       <= 2'd0;
            mix_q       <= '0;
            s_q         <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mix_q       <= mix_d;
            s_q         <= s_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_xsr_arbiter.sv
// tb_xsr_arbiter: directed self-checking bench for xsr_arbiter (NREQ=4).
// Expected generator values come from an independent splitmix64/xoshiro256** model.
// The reseed scenario runs only when XSR_ARB_RESEED_EN is defined.
module tb_xsr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [63:0]     seed;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            out_valid;
    logic [IDW-1:0]  out_id;
    logic [63:0]     out_data;
    logic            ready;
`ifdef XSR_ARB_RESEED_EN
    logic            reseed;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] m_s [4];
    logic [63:0] exp_v;
    logic [63:0] first_seed0;

    always #5 clk = ~clk;

    xsr_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed      (seed),
        .req       (req),
`ifdef XSR_ARB_RESEED_EN
        .reseed    (reseed),
`endif
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data),
        .ready     (ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_rotl(input logic [63:0] x, input int k);
        return (x << k) | (x >> (64 - k));
    endfunction

    function automatic logic [63:0] m_mix(input logic [63:0] v);
        logic [63:0] z;
        z = v;
        z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
        z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
        return z ^ (z >> 31);
    endfunction

    task automatic m_seed(input logic [63:0] sd);
        logic [63:0] mix;
        mix = sd;
        for (int i = 0; i < 4; i++) begin
            mix    = mix + 64'h9E3779B97F4A7C15;
            m_s[i] = m_mix(mix);
        end
    endtask

    task automatic m_next(output logic [63:0] r);
        logic [63:0] t;
        r      = m_rotl(m_s[1] * 64'd5, 7) * 64'd9;
        t      = m_s[1] << 17;
        m_s[2] = m_s[2] ^ m_s[0];
        m_s[3] = m_s[3] ^ m_s[1];
        m_s[1] = m_s[1] ^ m_s[2];
        m_s[0] = m_s[0] ^ m_s[3];
        m_s[2] = m_s[2] ^ t;
        m_s[3] = m_rotl(m_s[3], 45);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst  = 1'b1;
        seed = 64'h0;
        req  = '0;
`ifdef XSR_ARB_RESEED_EN
        reseed = 1'b0;
`endif
        // Test 1: reset values, seeding latency, s0, first value for seed 0.
        tick();
        tick();
        settle();
        check_eq("rst_gnt", 64'(gnt), 64'h0);
        check_eq("rst_valid", 64'(out_valid), 64'h0);
        check_eq("rst_id", 64'(out_id), 64'h0);
        check_eq("rst_data", out_data, 64'h0);
        check_eq("rst_ready", 64'(ready), 64'h0);
        rst = 1'b0;
        m_seed(64'h0);
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("t1_ready_low", 64'(ready), 64'h0);
            tick();
        end
        settle();
        check_eq("t1_ready_high", 64'(ready), 64'h1);
        check_eq("t1_s0", dut.s_q.s0, 64'hE220A8397B1DCDAF);
        req = 4'b0001;
        settle();
        check_eq("t1_gnt", 64'(gnt), 64'h1);
        m_next(exp_v);
        first_seed0 = exp_v;
        tick();
        settle();
        check_eq("t1_valid", 64'(out_valid), 64'h1);
        check_eq("t1_id", 64'(out_id), 64'h0);
        check_eq("t1_data", out_data, exp_v);
        req = '0;

        // Test 2: all four requesting, rotating grants from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_seed(64'h0);
        repeat (4) tick();
        req = 4'b1111;
        settle();
        for (int k = 0; k < 8; k++) begin
            check_eq("t2_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
            m_next(exp_v);
            tick();
            settle();
            check_eq("t2_valid", 64'(out_valid), 64'h1);
            check_eq("t2_id", 64'(out_id), 64'(k % 4));
            check_eq("t2_data", out_data, exp_v);
        end

        // Test 3: idle cycle holds outputs; lone req 2 wins after a grant to 3.
        req = '0;
        settle();
        check_eq("t3_idle_gnt", 64'(gnt), 64'h0);
        tick();
        settle();
        check_eq("t3_idle_valid", 64'(out_valid), 64'h0);
        check_eq("t3_idle_data", out_data, exp_v);
        check_eq("t3_idle_id", 64'(out_id), 64'h3);
        req = 4'b0100;
        settle();
        check_eq("t3_gnt", 64'(gnt), 64'h4);
        m_next(exp_v);
        tick();
        settle();
        check_eq("t3_id", 64'(out_id), 64'h2);
        check_eq("t3_data", out_data, exp_v);
        check_eq("t3_rr_ptr", 64'(dut.rr_ptr_q), 64'h3);
        check_eq("t3_gnt_again", 64'(gnt), 64'h4);
        m_next(exp_v);
        tick();
        settle();
        check_eq("t3_data2", out_data, exp_v);
        req = '0;

        // Test 4: requests held through seeding are not granted until RUN.
        rst = 1'b1;
        req = 4'b1111;
        tick();
        rst = 1'b0;
        m_seed(64'h0);
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("t4_gnt_seed", 64'(gnt), 64'h0);
            check_eq("t4_ready_seed", 64'(ready), 64'h0);
            tick();
        end
        settle();
        check_eq("t4_ready", 64'(ready), 64'h1);
        check_eq("t4_gnt", 64'(gnt), 64'h1);
        m_next(exp_v);
        tick();
        settle();
        check_eq("t4_data", out_data, exp_v);
        req = '0;

        // Test 5: rst coincident with a grant drops it; sequence restarts as in Test 1.
        req = 4'b0010;
        settle();
        check_eq("t5_gnt", 64'(gnt), 64'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        settle();
        check_eq("t5_no_valid", 64'(out_valid), 64'h0);
        m_seed(64'h0);
        for (int k = 0; k < 4; k++) begin
            check_eq("t5_ready_low", 64'(ready), 64'h0);
            tick();
            settle();
        end
        check_eq("t5_ready", 64'(ready), 64'h1);
        req = 4'b0001;
        settle();
        m_next(exp_v);
        tick();
        settle();
        check_eq("t5_valid", 64'(out_valid), 64'h1);
        check_eq("t5_data", out_data, first_seed0);
        req = '0;

`ifdef XSR_ARB_RESEED_EN
        // Test 6: reseed in RUN blocks grants for 5 cycles, then seed 0x1234 sequence.
        seed   = 64'h1234;
        req    = 4'b1111;
        reseed = 1'b1;
        settle();
        check_eq("t6_gnt_reseed", 64'(gnt), 64'h0);
        tick();
        reseed = 1'b0;
        m_seed(64'h1234);
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("t6_gnt_seed", 64'(gnt), 64'h0);
            check_eq("t6_ready_low", 64'(ready), 64'h0);
            tick();
        end
        settle();
        check_eq("t6_ready", 64'(ready), 64'h1);
        check_eq("t6_gnt1", 64'(gnt), 64'h2);
        m_next(exp_v);
        tick();
        settle();
        check_eq("t6_id1", 64'(out_id), 64'h1);
        check_eq("t6_data1", out_data, exp_v);
        check_eq("t6_gnt2", 64'(gnt), 64'h4);
        m_next(exp_v);
        tick();
        settle();
        check_eq("t6_id2", 64'(out_id), 64'h2);
        check_eq("t6_data2", out_data, exp_v);
        req = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
